fifo_spi_framer: RTL

FIFO_SPI_FRAMER -- requirements
Module: fifo_spi_framer

---
 rtl/fifo_spi_framer_pkg.sv | 28 ++
 rtl/fifo_spi_framer_checksum.sv | 28 ++
 rtl/fifo_spi_framer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fifo_spi_framer_pkg.sv
// Shared types and constants for the FIFO-to-SPI frame builder.
// Holds FSM/word-selector encodings and the FIFO read latency.
package fifo_spi_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_READ,
        ST_LAT
    } state_t;

    typedef enum logic [1:0] {
        WS_HDR,
        WS_SEQ,
        WS_SAMPLE,
        WS_CSUM
    } word_sel_t;

    localparam int FIFO_RD_LAT = 2;
    localparam int CSUM_W      = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fifo_spi_framer_checksum.sv
// Running 16-bit frame checksum: clear at frame start,
// accumulate each sequence/sample word as it is issued.
module framer_checksum
    import fifo_spi_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_serial,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_acc,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [CSUM_W-1:0]     o_sum
);

    logic [CSUM_W-1:0] r_sum;

    always_ff @(posedge clk_serial) begin
        if (rst || i_clear) begin
            r_sum <= '0;
        end else if (i_acc) begin
            r_sum <= r_sum + CSUM_W'(i_word);
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/fifo_spi_framer.sv
// Pulls samples from a non-FWFT FIFO and emits framed words
// (sync, sequence, samples, checksum) to an SPI master.
module fifo_spi_framer
    import fifo_spi_framer_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    FRAME_LEN      = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD      = 16'hA5A5,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD       = 16'hFFFF,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_serial,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  spi_go,
    output logic [DATA_WIDTH-1:0] spi_data,
    input  logic                  spi_ss_n,
    output logic [7:0]            frame_seq,
    output logic                  frame_done,
    output logic [15:0]           pad_count
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int LAT_W = $clog2(FIFO_RD_LAT) + 1;

    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(FIFO_RD_LAT - 1);
    localparam logic [7:0]       LAST_SAMPLE = 8'(FRAME_LEN - 1);

    state_t                r_state;
    word_sel_t             r_sel;
    logic                  r_spi_go;
    logic [DATA_WIDTH-1:0] r_spi_data;
    logic [7:0]            r_seq;
    logic                  r_done;
    logic [15:0]           r_pad_cnt;
    logic [TO_W-1:0]       r_timeout;
    logic [LAT_W-1:0]      r_lat;
    logic [7:0]            r_sample_idx;
    logic                  r_csum_clr;
    logic                  r_csum_acc;

    logic [CSUM_W-1:0]     w_csum;
    logic                  w_rd_en;

    // Combinational strobe so it can never coincide with an empty FIFO.
    assign w_rd_en = (r_state == ST_READ) && !fifo_empty && !rst;

    framer_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk_serial (clk_serial),
        .rst        (rst),
        .i_clear    (r_csum_clr),
        .i_acc      (r_csum_acc),
        .i_word     (r_spi_data),
        .o_sum      (w_csum)
    );

    always_ff @(posedge clk_serial) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= WS_HDR;
            r_spi_go     <= 1'b0;
            r_spi_data   <= '0;
            r_seq        <= '0;
            r_done       <= 1'b0;
            r_pad_cnt    <= '0;
            r_timeout    <= '0;
            r_lat        <= '0;
            r_sample_idx <= '0;
            r_csum_clr   <= 1'b0;
            r_csum_acc   <= 1'b0;
        end else begin
            r_spi_go   <= 1'b0;
            r_done     <= 1'b0;
            r_csum_clr <= 1'b0;
            r_csum_acc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_spi_data <= SYNC_WORD;
                        r_spi_go   <= 1'b1;
                        r_sel      <= WS_HDR;
                        r_csum_clr <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (!spi_ss_n) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_ss_n) begin
                        unique case (r_sel)
                            WS_HDR: begin
                                r_spi_data <= DATA_WIDTH'({8'h00, r_seq});
                                r_csum_acc <= 1'b1;
                                r_spi_go   <= 1'b1;
                                r_sel      <= WS_SEQ;
                                r_state    <= ST_SEND;
                            end
                            WS_SEQ: begin
                                r_sel        <= WS_SAMPLE;
                                r_sample_idx <= '0;
                                r_timeout    <= '0;
                                r_state      <= ST_READ;
                            end
                            WS_SAMPLE: begin
                                if (r_sample_idx == LAST_SAMPLE) begin
                                    r_spi_data <= DATA_WIDTH'(w_csum);
                                    r_spi_go   <= 1'b1;
                                    r_sel      <= WS_CSUM;
                                    r_state    <= ST_SEND;
                                end else begin
                                    r_sample_idx <= r_sample_idx + 8'd1;
                                    r_timeout    <= '0;
                                    r_state      <= ST_READ;
                                end
                            end
                            WS_CSUM: begin
                                r_done  <= 1'b1;
                                r_seq   <= r_seq + 8'd1;
                                r_sel   <= WS_HDR;
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    if (!fifo_empty) begin
                        r_timeout <= '0;
                        r_lat     <= '0;
                        r_state   <= ST_LAT;
                    end else if (r_timeout == TO_LAST) begin
                        r_timeout  <= '0;
                        r_spi_data <= PAD_WORD;
                        r_csum_acc <= 1'b1;
                        r_pad_cnt  <= sat_inc16(r_pad_cnt);
                        r_spi_go   <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end
                ST_LAT: begin
                    if (r_lat == LAT_LAST) begin
                        r_spi_data <= fifo_data;
                        r_csum_acc <= 1'b1;
                        r_spi_go   <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign spi_go     = r_spi_go;
    assign spi_data   = r_spi_data;
    assign frame_seq  = r_seq;
    assign frame_done = r_done;
    assign pad_count  = r_pad_cnt;

endmodule
